bcd_counter_display: RTL
========================

Name: bcd_counter_display

Overview:
- Parametrised multi-digit BCD up/down counter with synchronous load, driving a time-multiplexed common-anode seven-segment display.
- Generalises the single-digit counter to NUM_DIGITS with ripple carry/borrow, count direction, internal tick prescaler, async reset, load validation and digit scanning.
- Sits between board switches/buttons and the on-board display.

Parameters:
- NUM_DIGITS, 4, number of BCD digits and display anodes (1..8).
- TICK_DIV, 100000000, clk cycles per count tick (>=2).
- REFRESH_DIV, 100000, clk cycles each digit is lit per scan slot (>=1).
- BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 always shown).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  count enable, sampled on tick.
- load  in  1  synchronous load strobe.
- up_down  in  1  1 = count up, 0 = count down.
- w  in  4*NUM_DIGITS  BCD load value, digit i at w[4i+3:4i].
- count  out  4*NUM_DIGITS  current BCD value.
- wrap  out  1  one-cycle pulse on full-range wrap.
- load_err  out  1  one-cycle pulse when a loaded nibble was >9.
- seg  out  [0:6]  segments a..g, active-low, seg[0]=a.
- digit  out  NUM_DIGITS  anodes, active-low, one-hot-low while scanning.

Behaviour:
- Reset (async on rst_n low, released synchronously by clk): count=0, wrap=0, load_err=0, tick counter=0, scan index=0, refresh counter=0, seg=7'b1111111, digit=all ones.
- Tick: free-running counter 0..TICK_DIV-1; tick asserted for the one cycle it equals TICK_DIV-1, then it returns to 0. Not affected by load or enable.
- Priority per edge: load > (tick & enable) > hold.
- Load: count <= w on the same edge, regardless of tick/enable. Any nibble >9 is stored as 0 and load_err pulses the following cycle. Valid nibbles are stored unchanged.
- Up (tick & enable & up_down & !load):
  - Digit 0 +1; any digit going 9->0 carries into the next digit.
  - All-9s -> all-0s and wrap pulses for one cycle.
- Down: digit 0 -1; any digit going 0->9 borrows from the next digit. All-0s -> all-9s and wrap pulses.
- Count is never outside 0..9 per nibble.
- Counting never changes count more than once per tick.
- Scan:
  - Refresh counter 0..REFRESH_DIV-1. At REFRESH_DIV-1 the scan index advances; it wraps NUM_DIGITS-1 -> 0.
  - digit and seg are registered, one cycle after index/count: digit[index]=0 and others 1; seg = decode(count nibble[index]).
  - Leading-zero blanking (BLANK_LZ=1): a digit with index>0 that is 0 and whose higher digits are all 0 drives seg=1111111, with its anode still driven.
- Decode (abcdefg, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Reset mid-count/mid-scan: immediate return to reset values, no wrap/load_err pulse generated.
- Load on the same edge as a wrap-causing tick: load wins, no wrap pulse.

Test Plan (NUM_DIGITS=4, TICK_DIV=4, REFRESH_DIV=2):
- Reset, enable=1, up_down=1 for 40 cycles -> count 0000,0001,... advancing every 4 cycles, reaches 0010 after 10th tick (digit 1 carry).
- Load w=16'h9998, up -> after 2 ticks count=0000, wrap high exactly 1 cycle at the 9999->0000 edge.
- Load w=16'h0000, up_down=0 -> next tick count=9999, wrap pulses; next tick 9998.
- Load w=16'h12A4 -> count=1204, load_err pulses one cycle; enable=0 for 20 cycles -> count holds 1204.
- count=0305, monitor 16 cycles -> digit sequence 1110,1101,1011,0111 each held 2 cycles; seg 0100100,0000001,0000110,0000001. With BLANK_LZ=1 and count=0005, digits 1..3 show 1111111.
- Assert rst_n low mid-tick with count=4321 -> count=0000, seg=1111111, digit=1111 immediately (before next clk edge).

Source files
------------

// File: rtl/bcd_counter_display.sv
// bcd_counter_display
//   Multi-digit BCD up/down counter with synchronous load and an internal tick
//   prescaler. It drives a time-multiplexed, common-anode seven-segment display.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   enable    count enable, sampled on tick
//   load      synchronous load strobe (has priority over counting)
//   up_down   1 = count up, 0 = count down
//   w         BCD load value, digit i at w[4i+3:4i]
//   count     current BCD value
//   wrap      one-cycle pulse on a full-range wrap (all-9s <-> all-0s)
//   load_err  one-cycle pulse after a load that contained a nibble > 9
//   seg       segments a..g, active-low, seg[0] = a
//   digit     anodes, active-low, one-hot-low while scanning
module bcd_counter_display #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned TICK_DIV    = 100000000,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_LZ    = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic                    up_down,
    input  logic [4*NUM_DIGITS-1:0] w,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    wrap,
    output logic                    load_err,
    output logic [0:6]              seg,
    output logic [NUM_DIGITS-1:0]   digit
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RefW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
    localparam logic [RefW-1:0]  RefMax  = RefW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0]  IdxMax  = IdxW'(NUM_DIGITS - 1);

    // Active-low segment pattern, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'b0000001;
            4'd1:    pat = 7'b1001111;
            4'd2:    pat = 7'b0010010;
            4'd3:    pat = 7'b0000110;
            4'd4:    pat = 7'b1001100;
            4'd5:    pat = 7'b0100100;
            4'd6:    pat = 7'b0100000;
            4'd7:    pat = 7'b0001111;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0000100;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    logic [TickW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [RefW-1:0]         ref_cnt_q, ref_cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] count_q, count_d;
    logic                    wrap_q, wrap_d;
    logic                    load_err_q, load_err_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   digit_q, digit_d;

    logic                    tick;
    logic                    ref_wrap;
    logic [4*NUM_DIGITS-1:0] step_val;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic                    carry;
    logic                    bad_nib;
    logic [3:0]              cnt_nib;
    logic [3:0]              w_nib;
    logic [3:0]              sel_nib;
    logic                    zero_above;

    // Free-running prescaler, independent of load and enable.
    always_comb begin
        tick       = (tick_cnt_q == TickMax);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Counter next state: load > (tick & enable) > hold.
    always_comb begin
        step_val   = count_q;
        load_val   = '0;
        carry      = 1'b1;
        bad_nib    = 1'b0;
        cnt_nib    = '0;
        w_nib      = '0;
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;

        // Ripple carry/borrow; carry out of the top digit is the wrap condition.
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            cnt_nib = count_q[4*i +: 4];
            if (carry) begin
                if (up_down) begin
                    if (cnt_nib == 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = cnt_nib + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (cnt_nib == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = cnt_nib - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end

        // Invalid load nibbles are stored as zero.
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            w_nib = w[4*i +: 4];
            if (w_nib > 4'd9) begin
                bad_nib = 1'b1;
            end else begin
                load_val[4*i +: 4] = w_nib;
            end
        end

        if (load) begin
            count_d    = load_val;
            load_err_d = bad_nib;
        end else if (tick && enable) begin
            count_d = step_val;
            wrap_d  = carry;
        end
    end

    // Scan slot timing and digit index.
    always_comb begin
        ref_wrap  = (ref_cnt_q == RefMax);
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (ref_wrap) begin
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
        end
    end

    // Display drive, registered from the current index and count.
    always_comb begin
        digit_d    = '1;
        seg_d      = 7'b1111111;
        sel_nib    = '0;
        zero_above = 1'b1;
        // Walk from the top digit so zero_above means "this and all higher digits are 0".
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_above = zero_above && (count_q[4*i +: 4] == 4'd0);
            if (IdxW'(i) == idx_q) begin
                sel_nib    = count_q[4*i +: 4];
                digit_d[i] = 1'b0;
                if (BLANK_LZ && (i > 0) && zero_above) begin
                    seg_d = 7'b1111111;
                end else begin
                    seg_d = seg_decode(sel_nib);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            ref_cnt_q  <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
            seg_q      <= 7'b1111111;
            digit_q    <= '1;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
            seg_q      <= seg_d;
            digit_q    <= digit_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
    assign seg      = seg_q;
    assign digit    = digit_q;

endmodule
